// File: rtl/sd_pkg.sv
// sd_pkg: CIC order and width/shift helpers shared by the sigma-delta modulator and decimator
package sd_pkg;
    localparam int CIC_ORDER = 3;
    function automatic int cic_width(input int dec_log2);
        return CIC_ORDER * dec_log2 + 2;
    endfunction
    function automatic int cic_shift(input int dec_log2, input int bw);
        return CIC_ORDER * dec_log2 + 1 - bw;
    endfunction
endpackage

// File: rtl/cic_comb.sv
// cic_comb: W-bit differentiator y = x - x(previous enabled sample)
// clk_i/rst_i: clock, async active-low reset; en_i: advance delay; x_i: input; y_o: difference
module cic_comb
    import sd_pkg::*;
#(
    parameter int W = cic_width(6)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);
    logic [W-1:0] dly_q, dly_d;
    always_comb begin
        dly_d = en_i ? x_i : dly_q;
        y_o   = x_i - dly_q;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) dly_q <= '0;
        else        dly_q <= dly_d;
    end
endmodule

// File: rtl/sd_decimator.sv
// sd_decimator: 3rd-order CIC decimator turning a 1-bit sigma-delta stream into BW-bit samples
// clk_i/rst_i: clock, async active-low reset; bit_i/bit_en_i: bitstream and its qualifier
// sample_o/valid_o: saturated decimated sample and its one-cycle strobe
module sd_decimator
    import sd_pkg::*;
#(
    parameter int BW       = 14,
    parameter int DEC_LOG2 = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bit_i,
    input  logic                 bit_en_i,
    output logic signed [BW-1:0] sample_o,
    output logic                 valid_o
);
    localparam int W = cic_width(DEC_LOG2);
    localparam int S = cic_shift(DEC_LOG2, BW);
    if (S < 0 || DEC_LOG2 < 1) begin : g_bad_params
        $error("sd_decimator: need 3*DEC_LOG2+1 >= BW and DEC_LOG2 >= 1");
    end
    localparam logic signed [W-1:0] max_v = {{(S + 1){1'b0}}, {(BW - 1){1'b1}}};
    localparam logic signed [W-1:0] min_v = ~max_v;
    logic [W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d, smp_q, smp_d;
    logic [DEC_LOG2-1:0] cnt_q, cnt_d;
    logic dec_q, dec_d, valid_q, valid_d;
    logic [1:0] warm_q, warm_d;
    logic signed [BW-1:0] sample_q, sample_d, sat;
    logic signed [W-1:0] sh;
    logic [W-1:0] c [CIC_ORDER+1];
    assign c[0] = smp_q;
    for (genvar i = 0; i < CIC_ORDER; i++) begin : g_comb
        cic_comb #(.W(W)) u_comb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (dec_q),
            .x_i   (c[i]),
            .y_o   (c[i+1])
        );
    end
    always_comb begin
        i1_d  = i1_q;
        i2_d  = i2_q;
        i3_d  = i3_q;
        cnt_d = cnt_q;
        smp_d = smp_q;
        dec_d = 1'b0;
        if (bit_en_i) begin
            i1_d  = i1_q + (bit_i ? W'(1) : '1);
            i2_d  = i2_q + i1_d;
            i3_d  = i3_q + i2_d;
            cnt_d = cnt_q + DEC_LOG2'(1);
            dec_d = &cnt_q;
            smp_d = (&cnt_q) ? i3_d : smp_q;
        end
        sh  = $signed(c[CIC_ORDER]) >>> S;
        sat = (sh > max_v) ? max_v[BW-1:0] : (sh < min_v) ? min_v[BW-1:0] : sh[BW-1:0];
        // the first two comb outputs see a partly filled window, so they only advance warm-up
        warm_d   = dec_q ? warm_q + {1'b0, ~&warm_q} : warm_q;
        valid_d  = dec_q & warm_q[1];
        sample_d = valid_d ? sat : sample_q;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            smp_q    <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            warm_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            i3_q     <= i3_d;
            smp_q    <= smp_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            warm_q   <= warm_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end
    assign sample_o = sample_q;
    assign valid_o  = valid_q;
endmodule

// File: doc/sd_decimator.md
SD_DECIMATOR -- requirements
Module: sd_decimator

Interface
REQ-001 SHALL have parameter BW, default 14: output sample width in bits, signed two's complement.
REQ-002 SHALL have parameter DEC_LOG2, default 6: log2 of the decimation ratio, so DEC = 2^DEC_LOG2.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port bit_i, input, 1 bit: 1-bit sigma-delta bitstream, the same format the team's DAC modulator emits on dac_o.
REQ-006 SHALL have port bit_en_i, input, 1 bit: qualifies bit_i; a bit is accepted only in cycles where bit_en_i=1.
REQ-007 SHALL have port sample_o, output, BW bits, signed: decimated sample.
REQ-008 SHALL have port valid_o, output, 1 bit: one-cycle strobe marking a new sample_o.

Function
REQ-009 SHALL implement a 3rd-order CIC (sinc3) decimator with ratio DEC: 3 integrators at the input rate and 3 combs at the output rate.
REQ-010 SHALL map each accepted bit to a signed input value: bit_i=1 -> +1, bit_i=0 -> -1.
REQ-011 SHALL give integrators and combs width W = 3*DEC_LOG2+2, using modular two's-complement arithmetic; integrator wrap-around is intentional and SHALL NOT be saturated.
REQ-012 SHALL update the integrators and the decimation counter (0..DEC-1) only on accepted bits; bit_en_i=0 SHALL freeze all state, with no valid_o generated.
REQ-013 SHALL latch the 3rd integrator on the edge that accepts a bit while the counter equals DEC-1, and wrap the counter to 0 on that edge.
REQ-014 SHALL, on the following edge, compute the 3 combs (each a delay of 1 decimated sample) and register sample_o and valid_o: fixed latency of 1 cycle after the decimation edge, independent of bit_en_i.
REQ-015 SHALL scale the comb result c (range -2^(3*DEC_LOG2) .. +2^(3*DEC_LOG2)) by an arithmetic right shift of S = 3*DEC_LOG2+1-BW bits.
REQ-016 SHALL saturate the shifted result to [-2^(BW-1), 2^(BW-1)-1]; positive full scale maps to 2^(BW-1)-1.
REQ-017 SHALL hold valid_o high for exactly one cycle per decimated sample, and hold sample_o stable between strobes.
REQ-018 SHALL suppress valid_o for the first 2 decimated samples after reset (comb warm-up), using a 2-bit saturating warm-up counter; the 3rd and all later samples SHALL strobe.
REQ-019 SHALL elaborate only when S >= 0 (i.e. 3*DEC_LOG2+1 >= BW) and DEC_LOG2 >= 1; any other parameter set SHALL be a compile-time error.

Reset
REQ-020 SHALL, while rst_i=0, clear the integrators, comb delays, decimation counter and warm-up counter to 0, and drive sample_o=0 and valid_o=0, regardless of clock.
REQ-021 SHALL, when reset is asserted mid-frame, discard the partial frame, and the warm-up of REQ-018 SHALL restart after release.
REQ-022 SHALL accept its first bit on the first rising edge with rst_i=1 and bit_en_i=1.

Structure
REQ-023 SHALL place the CIC order constant (3) and the width and shift functions for W and S in a shared package, sd_pkg, which the DAC modulator also uses.
REQ-024 SHALL instantiate one sub-module, cic_comb, once per comb stage: a W-bit registered differentiator with an enable input.

Verification
REQ-025 SHALL cover: BW=14, DEC_LOG2=6, bit_i=1 constant, bit_en_i=1 -> no strobe for 2 frames; then sample_o=8191 (saturated) every 64 cycles, each valid_o 1 cycle wide.
REQ-026 SHALL cover: bit_i=0 constant -> sample_o=-8192 from the 3rd strobe onward.
REQ-027 SHALL cover: bit_i alternating 1,0 -> sample_o=0 from the 3rd strobe onward.
REQ-028 SHALL cover: 3 ones then 1 zero repeating (mean +0.5) -> sample_o=4096 from the 3rd strobe onward.
REQ-029 SHALL cover: bit_en_i=1 on 1 cycle in 4 with bit_i=1 -> strobe period 256 cycles, same values as REQ-025, and no valid_o while bit_en_i=0.
REQ-030 SHALL cover: rst_i pulsed low for 3 cycles at bit 100 of a constant-ones stream -> outputs 0 during reset, 2 suppressed frames, first strobe 8191 at 192 accepted bits + 1 cycle after release.
